// File: rtl/l2_arb_pkg.sv
// Shared types for the two-port L2 request arbiter.
package l2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TURN
  } state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

  typedef logic owner_t;

  // Write wins when a requester raises both levels.
  function automatic op_t op_sel(
    input logic rd,
    input logic wr
  );
    op_sel = wr ? OP_WR : OP_RD;
    if (!rd && !wr) op_sel = OP_RD;
  endfunction

endpackage

// File: rtl/l2_port_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins,
// a tie goes to the port that did not win last.
module rr_arbiter2
  import l2_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last,
  output owner_t     pick,
  output logic       any
);

  always_comb begin
    any  = |req;
    pick = 1'b0;
    unique case (1'b1)
      (req == 2'b11): pick = ~last;
      (req == 2'b10): pick = 1'b1;
      default:        pick = 1'b0;
    endcase
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares one L2 request port between the I-cache (port 0)
// and D-cache (port 1) with round-robin grant and a watchdog.
module l2_port_arbiter
  import l2_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int L1_BLOCK_SIZE  = 16,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [ADDR_WIDTH-1:0]               p0_addr,
  input  logic [L1_BLOCK_SIZE*DATA_WIDTH-1:0] p0_wdata,
  input  logic                                p0_read,
  input  logic                                p0_write,
  output logic [L1_BLOCK_SIZE*DATA_WIDTH-1:0] p0_rdata,
  output logic                                p0_ready,
  output logic                                p0_err,
  input  logic [ADDR_WIDTH-1:0]               p1_addr,
  input  logic [L1_BLOCK_SIZE*DATA_WIDTH-1:0] p1_wdata,
  input  logic                                p1_read,
  input  logic                                p1_write,
  output logic [L1_BLOCK_SIZE*DATA_WIDTH-1:0] p1_rdata,
  output logic                                p1_ready,
  output logic                                p1_err,
  output logic [ADDR_WIDTH-1:0]               l2_addr,
  output logic [L1_BLOCK_SIZE*DATA_WIDTH-1:0] l2_wdata,
  output logic                                l2_read,
  output logic                                l2_write,
  input  logic [L1_BLOCK_SIZE*DATA_WIDTH-1:0] l2_rdata,
  input  logic                                l2_ready,
  output logic                                busy
);

  localparam int LW  = L1_BLOCK_SIZE * DATA_WIDTH;
  localparam int WDW = (TIMEOUT_CYCLES > 0) ?
                       $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t               state, state_d;
  owner_t               rr_last, owner, pick;
  op_t                  op;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LW-1:0]         wdata_q;
  logic [WDW-1:0]        wd;
  logic                  any, in_grant, expire, done, err;
  logic [LW-1:0]         rdata_mux;

  rr_arbiter2 u_rr (
    .req  ({p1_read | p1_write, p0_read | p0_write}),
    .last (rr_last),
    .pick (pick),
    .any  (any)
  );

  always_comb begin
    in_grant  = (state == GRANT);
    expire    = in_grant && (TIMEOUT_CYCLES != 0) && (wd == '0);
    done      = in_grant && (l2_ready || expire);
    err       = expire && !l2_ready;
    rdata_mux = (in_grant && l2_ready) ? l2_rdata : '0;
    l2_addr   = in_grant ? addr_q : '0;
    l2_wdata  = in_grant ? wdata_q : '0;
    // Dropped in the ready cycle so L2 never sees a second request.
    l2_read   = in_grant && (op == OP_RD) && !done;
    l2_write  = in_grant && (op == OP_WR) && !done;
    p0_ready  = done && (owner == 1'b0);
    p1_ready  = done && (owner == 1'b1);
    p0_err    = err && (owner == 1'b0);
    p1_err    = err && (owner == 1'b1);
    p0_rdata  = (owner == 1'b0) ? rdata_mux : '0;
    p1_rdata  = (owner == 1'b1) ? rdata_mux : '0;
    busy      = (state != IDLE);
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (any) state_d = GRANT;
      GRANT:   if (done) state_d = TURN;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_last <= 1'b1;
      owner   <= 1'b0;
      op      <= OP_RD;
      addr_q  <= '0;
      wdata_q <= '0;
      wd      <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && any) begin
        owner   <= pick;
        rr_last <= pick;
        addr_q  <= pick ? p1_addr : p0_addr;
        wdata_q <= pick ? p1_wdata : p0_wdata;
        op      <= pick ? op_sel(p1_read, p1_write)
                        : op_sel(p0_read, p0_write);
        wd      <= WDW'(TIMEOUT_CYCLES);
      end else if (in_grant && wd != '0) begin
        wd <= wd - WDW'(1);
      end
    end
  end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Random two-requester traffic against a transaction-level
// model of the arbiter, with a random-latency L2 responder.
module tb_l2_port_arbiter;

  localparam int DW = 8;
  localparam int AW = 16;
  localparam int BS = 2;
  localparam int TO = 12;
  localparam int LW = DW * BS;
  localparam int NCYC = 3000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] p0_addr, p1_addr, l2_addr;
  logic [LW-1:0] p0_wdata, p1_wdata, l2_wdata;
  logic [LW-1:0] p0_rdata, p1_rdata, l2_rdata;
  logic          p0_read, p0_write, p0_ready, p0_err;
  logic          p1_read, p1_write, p1_ready, p1_err;
  logic          l2_read, l2_write, l2_ready, busy;

  logic          rd [2];
  logic          wr [2];
  logic [AW-1:0] addr [2];
  logic [LW-1:0] wdat [2];
  bit            served [2];

  assign p0_read  = rd[0];
  assign p0_write = wr[0];
  assign p0_addr  = addr[0];
  assign p0_wdata = wdat[0];
  assign p1_read  = rd[1];
  assign p1_write = wr[1];
  assign p1_addr  = addr[1];
  assign p1_wdata = wdat[1];

  l2_port_arbiter #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .L1_BLOCK_SIZE  (BS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .p0_addr  (p0_addr),
    .p0_wdata (p0_wdata),
    .p0_read  (p0_read),
    .p0_write (p0_write),
    .p0_rdata (p0_rdata),
    .p0_ready (p0_ready),
    .p0_err   (p0_err),
    .p1_addr  (p1_addr),
    .p1_wdata (p1_wdata),
    .p1_read  (p1_read),
    .p1_write (p1_write),
    .p1_rdata (p1_rdata),
    .p1_ready (p1_ready),
    .p1_err   (p1_err),
    .l2_addr  (l2_addr),
    .l2_wdata (l2_wdata),
    .l2_read  (l2_read),
    .l2_write (l2_write),
    .l2_rdata (l2_rdata),
    .l2_ready (l2_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errs    = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s @%0t: got %h expected %h",
               tag, $time, got, exp);
    end
  endtask

  // Reference state: who holds the port, how long it has waited.
  int            m_own;
  bit            m_turn;
  int            m_wait;
  int            m_last;
  int            m_lat;
  bit            m_wr;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;
  int            force_lat = -1;
  int            resets    = 0;
  int            cyc;

  function automatic bit m_expired();
    return (TO != 0) && (m_own >= 0) && (m_wait >= TO);
  endfunction

  task automatic model_step();
    bit a0, a1;
    int w;
    if (!rst_n) begin
      m_own  = -1;
      m_turn = 0;
      m_last = 1;
      return;
    end
    a0 = rd[0] | wr[0];
    a1 = rd[1] | wr[1];
    if (m_own >= 0) begin
      if (l2_ready || m_expired()) begin
        m_own  = -1;
        m_turn = 1;
      end else begin
        m_wait++;
      end
    end else if (m_turn) begin
      m_turn = 0;
    end else if (a0 || a1) begin
      if (a0 && a1) w = 1 - m_last;
      else          w = a1 ? 1 : 0;
      m_own   = w;
      m_last  = w;
      m_addr  = addr[w];
      m_wdata = wdat[w];
      m_wr    = wr[w];
      m_wait  = 0;
      m_lat   = (force_lat >= 0) ? force_lat
                                 : int'($urandom_range(1, 16));
      force_lat = -1;
    end
  endtask

  task automatic drive();
    int op;
    rst_n = (cyc >= 2);
    if (cyc > 2 && m_own >= 0 && m_wait >= 1 && resets < 4 &&
        ($urandom_range(0, 30) == 0 || (cyc > 400 && resets == 0))) begin
      rst_n = 1'b0;
      resets++;
    end
    for (int p = 0; p < 2; p++) begin
      if (served[p]) begin
        rd[p]     = 1'b0;
        wr[p]     = 1'b0;
        served[p] = 0;
      end else if (!rd[p] && !wr[p] && cyc > 2 &&
                   $urandom_range(0, 3) == 0) begin
        op      = int'($urandom_range(1, 3));
        rd[p]   = op[0];
        wr[p]   = op[1];
        addr[p] = AW'($urandom);
        wdat[p] = LW'($urandom);
      end
    end
    if (cyc == 2) begin
      rd[0]   = 1'b1;
      wr[0]   = 1'b0;
      addr[0] = 16'h0100;
      rd[1]   = 1'b0;
      wr[1]   = 1'b1;
      force_lat = 10;
    end
    l2_rdata = LW'($urandom);
    if (m_own >= 0) l2_ready = (m_wait == m_lat);
    else            l2_ready = ($urandom_range(0, 7) == 0);
  endtask

  task automatic check_outputs();
    bit            g, done, exp_err;
    logic [LW-1:0] rdv;
    g       = (m_own >= 0);
    done    = g && (l2_ready || m_expired());
    exp_err = done && !l2_ready;
    rdv     = (g && l2_ready) ? l2_rdata : '0;
    chk("busy",     busy,     g || m_turn);
    chk("l2_read",  l2_read,  g && !m_wr && !done);
    chk("l2_write", l2_write, g && m_wr && !done);
    chk("l2_addr",  l2_addr,  g ? m_addr : '0);
    chk("l2_wdata", l2_wdata, g ? m_wdata : '0);
    chk("p0_ready", p0_ready, done && m_own == 0);
    chk("p1_ready", p1_ready, done && m_own == 1);
    chk("p0_err",   p0_err,   exp_err && m_own == 0);
    chk("p1_err",   p1_err,   exp_err && m_own == 1);
    chk("p0_rdata", p0_rdata, (m_own == 0) ? rdv : '0);
    chk("p1_rdata", p1_rdata, (m_own == 1) ? rdv : '0);
    if (done) served[m_own] = 1;
  endtask

  initial begin
    rst_n    = 1'b0;
    l2_ready = 1'b0;
    l2_rdata = '0;
    m_own    = -1;
    m_turn   = 0;
    m_last   = 1;
    for (int p = 0; p < 2; p++) begin
      rd[p]     = 1'b0;
      wr[p]     = 1'b0;
      addr[p]   = '0;
      wdat[p]   = '0;
      served[p] = 0;
    end
    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      model_step();
      #1;
      drive();
      @(negedge clk);
      check_outputs();
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
